psram_test_sequencer: RTL and testbench
=======================================

// Module: psram_test_sequencer
// PURPOSE
//  Upstream traffic generator for one PSRAM channel of the 2-ch PSRAM controller wrapper.
//  Writes a selectable byte pattern over [0..END_ADDRESS], reads it back, compares each byte, reports pass/fail.
//  One instance per channel drives rd/wr/address/wdata; it consumes busy, initial_busy, rdata and rdata_en.
// PARAMETERS
//  END_ADDRESS   22'h3FFFFF  last byte address tested, inclusive; both phases start at 0
//  LFSR_SEED     16'hACE1    LFSR start value, reloaded at the start of each phase; must be non-zero
//  TIMEOUT_CYC   8'd255      max cycles in RD_WAIT without rdata_en before a byte is counted as an error
// PORTS
//  clk              in   1   system clock; same clock as the PSRAM controller user side
//  reset            in   1   synchronous, active-high
//  start            in   1   one-cycle pulse; honoured only in IDLE or DONE
//  pattern_sel      in   2   0: addr[7:0]; 1: LFSR[7:0]; 2: 55/AA alternating by addr[0]; 3: 00/FF alternating by addr[0]
//  running          out  1   high from start-accept until DONE
//  done             out  1   sticky; cleared by an accepted start
//  pass             out  1   valid when done=1; 1 iff error_count==0
//  error_count      out  16  mismatches plus timeouts; saturates at 16'hFFFF
//  timeout_seen     out  1   sticky; at least one read timed out
//  first_err_addr   out  22  address of the first error
//  first_err_exp    out  8   expected byte at the first error
//  first_err_act    out  8   actual byte at the first error; 8'h00 on timeout
//  mem_initial_busy in   1   controller calibration not complete
//  mem_busy         in   1   controller busy; registered; rises the cycle after a rd/wr it accepts
//  mem_wr           out  1   one-cycle write request
//  mem_rd           out  1   one-cycle read request
//  mem_address      out  22  byte address
//  mem_wdata        out  8   write data
//  mem_rdata        in   8   read data
//  mem_rdata_en     in   1   one-cycle read-data strobe
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: rd, wr, address, wdata, running, done, pass, error_count, timeout_seen, first_err_*.
//  FSM: IDLE -> WAIT_INIT -> WR_ISSUE <-> WR_WAIT -> RD_ISSUE <-> RD_WAIT -> DONE.
//  IDLE/DONE: on start, clear error state, done=0, running=1, addr=0, LFSR=LFSR_SEED, go to WAIT_INIT.
//  WAIT_INIT: stay while mem_initial_busy=1.
//  WR_ISSUE: when mem_busy=0, assert mem_wr for exactly one cycle with address and wdata valid in that cycle, go to WR_WAIT.
//   If mem_busy=1, hold mem_wr=0.
//  WR_WAIT: stay while mem_busy=1.
//   If addr==END_ADDRESS, go to RD_ISSUE with addr=0 and LFSR reloaded.
//   Otherwise addr+1, advance LFSR, return to WR_ISSUE.
//   Compare happens before increment, so there is no 22-bit wrap at 3FFFFF.
//  RD_ISSUE: when mem_busy=0, one-cycle mem_rd pulse, clear timeout counter, go to RD_WAIT.
//   mem_rd is never asserted for 2+ consecutive cycles, because the controller re-arms its read capture on every rd cycle.
//  RD_WAIT: on mem_rdata_en, compare mem_rdata against the regenerated expected byte.
//   On timeout (TIMEOUT_CYC cycles without mem_rdata_en), record an error with act=8'h00 and set timeout_seen.
//   Either way: if addr==END_ADDRESS go to DONE, else addr+1, advance LFSR, go to RD_ISSUE.
//  Error record: error_count++ (saturating).
//   first_err_* latched only when error_count was 0 before the increment.
//  DONE: running=0, done=1, pass=(error_count==0). Holds until start.
//  mem_rdata_en outside RD_WAIT: ignored.
//  start while running: ignored.
//  Reset mid-operation: immediate return to reset values. Any in-flight controller op is abandoned, with no rd/wr emitted.
//  LFSR: 16-bit Galois, right-shift, taps 16'hB400. Advances once per address in both phases, for every pattern_sel.
//  pattern_sel is sampled at start-accept and held internally for the whole run.
//  Latency per byte, best case: write = issue + controller busy window; read = issue + controller read latency to rdata_en.
// STRUCTURE
//  Package psram_test_pkg holds:
//   - FSM state encodings (3-bit)
//   - PATTERN_ADDR/LFSR/55AA/00FF constants
//   - LFSR_TAPS = 16'hB400
//  Sub-module psram_test_pattern_gen:
//   - inputs: clk, reset, load, advance, sel, addr
//   - output: expected byte
//   - contains the LFSR; shared by both phases so write and read data match by construction.
//  Top level holds the FSM, address counter, timeout counter and error bookkeeping.
// TESTING
//  Bench uses a behavioural model of the controller user side:
//   - busy high 14 cycles after wr, 4 after rd
//   - rdata_en about 6 cycles after rd
//   - byte-array storage
//  T1: END_ADDRESS=15, sel=0, start -> 16 wr pulses (data 00..0F), then 16 rd pulses; done=1, pass=1, error_count=0.
//  T2: sel=1, model flips bit0 at addr 5 -> error_count=1, first_err_addr=5, first_err_exp^first_err_act=8'h01, pass=0.
//  T3: model drops rdata_en at addr 3 -> advances after exactly TIMEOUT_CYC cycles; timeout_seen=1, first_err_addr=3, act=00.
//  T4: mem_initial_busy held 100 cycles after start -> no rd/wr until it falls; never two consecutive rd or wr cycles.
//  T5: reset asserted in RD_WAIT at addr 7 -> next cycle all outputs 0, state IDLE; a new start reruns from addr 0.
//  T6: END_ADDRESS=22'h3FFFFF, force addr to 3FFFFE -> last write at 3FFFFF, then reads start at 0, with no wrap write to 0.

Source files
------------

// File: rtl/psram_test_pkg.sv
// Shared types and constants for the PSRAM test sequencer: FSM states, pattern
// selectors and the LFSR step used to regenerate data in both phases.
package psram_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WR_ISSUE  = 3'd2,
    S_WR_WAIT   = 3'd3,
    S_RD_ISSUE  = 3'd4,
    S_RD_WAIT   = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PATTERN_ADDR = 2'd0,
    PATTERN_LFSR = 2'd1,
    PATTERN_55AA = 2'd2,
    PATTERN_00FF = 2'd3
  } pattern_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois form, right-shifting: the bit shifted out folds back through the taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/psram_test_pattern_gen.sv
// Expected-byte generator. One LFSR serves both phases, so the read phase
// regenerates exactly the byte stream the write phase produced.
module psram_test_pattern_gen
  import psram_test_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  pattern_e   sel,
  input  logic [7:0] addr,
  output logic [7:0] expected
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = SEED;
    else if (advance) lfsr_d = lfsr_step(lfsr_q);
  end

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values; = here would make results depend on process ordering.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  always_comb begin
    case (sel)
      PATTERN_ADDR: expected = addr;
      PATTERN_LFSR: expected = lfsr_q[7:0];
      PATTERN_55AA: expected = addr[0] ? 8'hAA : 8'h55;
      default:      expected = addr[0] ? 8'hFF : 8'h00;
    endcase
  end

endmodule

// File: rtl/psram_test_sequencer.sv
// Write/read-back/compare traffic generator for one PSRAM controller channel.
// Holds the FSM, address and timeout counters, and the error bookkeeping.
module psram_test_sequencer
  import psram_test_pkg::*;
#(
  parameter logic [21:0] END_ADDRESS = 22'h3FFFFF,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  output logic        running,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic        timeout_seen,
  output logic [21:0] first_err_addr,
  output logic [7:0]  first_err_exp,
  output logic [7:0]  first_err_act,
  input  logic        mem_initial_busy,
  input  logic        mem_busy,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [21:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rdata_en
);

  state_e      state_q, state_d;
  pattern_e    sel_q, sel_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        tmo_seen_q, tmo_seen_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [21:0] fe_addr_q, fe_addr_d;
  logic [7:0]  fe_exp_q, fe_exp_d;
  logic [7:0]  fe_act_q, fe_act_d;

  logic        pg_load, pg_advance, step, err_evt;
  logic [7:0]  err_act, exp_byte;

  psram_test_pattern_gen #(.SEED(LFSR_SEED)) u_pattern (
    .clk      (clk),
    .reset    (reset),
    .load     (pg_load),
    .advance  (pg_advance),
    .sel      (sel_q),
    .addr     (addr_q[7:0]),
    .expected (exp_byte)
  );

  // NOTE: every signal assigned below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    tmo_seen_d = tmo_seen_q;
    err_cnt_d  = err_cnt_q;
    fe_addr_d  = fe_addr_q;
    fe_exp_d   = fe_exp_q;
    fe_act_d   = fe_act_q;
    pg_load    = 1'b0;
    pg_advance = 1'b0;
    step       = 1'b0;
    err_evt    = 1'b0;
    err_act    = mem_rdata;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WAIT_INIT;
          sel_d      = pattern_e'(pattern_sel);
          addr_d     = '0;
          done_d     = 1'b0;
          tmo_seen_d = 1'b0;
          err_cnt_d  = '0;
          fe_addr_d  = '0;
          fe_exp_d   = '0;
          fe_act_d   = '0;
          pg_load    = 1'b1;
        end
      end
      S_WAIT_INIT: if (!mem_initial_busy) state_d = S_WR_ISSUE;
      S_WR_ISSUE: begin
        if (!mem_busy) begin
          mem_wr  = 1'b1;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        // Test the end address before incrementing: no wrap back to 0.
        if (!mem_busy) begin
          if (addr_q == END_ADDRESS) begin
            addr_d  = '0;
            pg_load = 1'b1;
            state_d = S_RD_ISSUE;
          end else begin
            addr_d     = addr_q + 22'd1;
            pg_advance = 1'b1;
            state_d    = S_WR_ISSUE;
          end
        end
      end
      S_RD_ISSUE: begin
        if (!mem_busy) begin
          mem_rd  = 1'b1;
          tmo_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // The wait lasts at most TIMEOUT_CYC cycles before the byte is abandoned.
        if (mem_rdata_en) begin
          err_evt = (mem_rdata != exp_byte);
          step    = 1'b1;
        end else if (tmo_q == TIMEOUT_CYC - 8'd1) begin
          err_evt    = 1'b1;
          err_act    = 8'h00;
          tmo_seen_d = 1'b1;
          step       = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        if (step) begin
          if (addr_q == END_ADDRESS) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d     = addr_q + 22'd1;
            pg_advance = 1'b1;
            state_d    = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_evt) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0) begin
        fe_addr_d = addr_q;
        fe_exp_d  = exp_byte;
        fe_act_d  = err_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= PATTERN_ADDR;
      addr_q     <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      tmo_seen_q <= 1'b0;
      err_cnt_q  <= '0;
      fe_addr_q  <= '0;
      fe_exp_q   <= '0;
      fe_act_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      tmo_seen_q <= tmo_seen_d;
      err_cnt_q  <= err_cnt_d;
      fe_addr_q  <= fe_addr_d;
      fe_exp_q   <= fe_exp_d;
      fe_act_q   <= fe_act_d;
    end
  end

  assign running        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = done_q;
  assign pass           = done_q && (err_cnt_q == 16'd0);
  assign error_count    = err_cnt_q;
  assign timeout_seen   = tmo_seen_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_act  = fe_act_q;
  assign mem_address    = addr_q;
  assign mem_wdata      = (state_q == S_WR_ISSUE) ? exp_byte : 8'h00;

endmodule

// File: tb/tb_psram_test_sequencer.sv
// Directed bench for psram_test_sequencer against a behavioural controller model.
`timescale 1ns/1ps
module tb_psram_test_sequencer;
  import psram_test_pkg::*;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 16-byte range.
  logic        reset = 1'b1, start = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        running, done, pass, timeout_seen;
  logic [15:0] error_count;
  logic [21:0] first_err_addr, mem_address;
  logic [7:0]  first_err_exp, first_err_act, mem_wdata, mem_rdata;
  logic        mem_initial_busy = 1'b0, mem_busy, mem_wr, mem_rd, mem_rdata_en;

  psram_test_sequencer #(.END_ADDRESS(22'd15)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel),
    .running(running), .done(done), .pass(pass), .error_count(error_count),
    .timeout_seen(timeout_seen), .first_err_addr(first_err_addr),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .mem_initial_busy(mem_initial_busy), .mem_busy(mem_busy),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_en(mem_rdata_en)
  );

  logic [89:0] outs;
  assign outs = {running, done, pass, error_count, timeout_seen, first_err_addr,
                 first_err_exp, first_err_act, mem_wr, mem_rd, mem_address, mem_wdata};

  // Full-range instance for the end-address boundary.
  logic        reset2 = 1'b1, start2 = 1'b0;
  logic        running2, done2, pass2, timeout_seen2;
  logic [15:0] error_count2;
  logic [21:0] first_err_addr2, mem_address2;
  logic [7:0]  first_err_exp2, first_err_act2, mem_wdata2;
  logic        mem_busy2, mem_wr2, mem_rd2;

  psram_test_sequencer #(.END_ADDRESS(22'h3FFFFF)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .pattern_sel(2'd0),
    .running(running2), .done(done2), .pass(pass2), .error_count(error_count2),
    .timeout_seen(timeout_seen2), .first_err_addr(first_err_addr2),
    .first_err_exp(first_err_exp2), .first_err_act(first_err_act2),
    .mem_initial_busy(1'b0), .mem_busy(mem_busy2),
    .mem_wr(mem_wr2), .mem_rd(mem_rd2), .mem_address(mem_address2),
    .mem_wdata(mem_wdata2), .mem_rdata(8'h00), .mem_rdata_en(1'b0)
  );

  // Controller model: busy 14 cycles after wr, 4 after rd; rdata_en 6 cycles after rd.
  logic       flip_en = 1'b0, drop_en = 1'b0;
  logic [7:0] m_mem [0:15];
  int         m_busy_cnt = 0, m_rd_cnt = 0, m_busy2_cnt = 0;
  logic [3:0] m_rd_idx = 4'd0;
  logic       m_rdata_en = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  always @(posedge clk) begin
    m_rdata_en <= 1'b0;
    if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
    if (m_rd_cnt != 0) begin
      m_rd_cnt <= m_rd_cnt - 1;
      if (m_rd_cnt == 1) begin
        m_rdata_en <= !(drop_en && m_rd_idx == 4'd3);
        m_rdata    <= m_mem[m_rd_idx] ^ {7'd0, flip_en && m_rd_idx == 4'd5};
      end
    end
    if (mem_wr) begin
      m_mem[mem_address[3:0]] <= mem_wdata;
      m_busy_cnt <= 14;
    end
    if (mem_rd) begin
      m_busy_cnt <= 4;
      m_rd_cnt   <= 5;
      m_rd_idx   <= mem_address[3:0];
    end
    if (m_busy2_cnt != 0) m_busy2_cnt <= m_busy2_cnt - 1;
    if (mem_wr2) m_busy2_cnt <= 14;
    if (mem_rd2) m_busy2_cnt <= 4;
  end

  assign mem_busy     = (m_busy_cnt != 0);
  assign mem_rdata    = m_rdata;
  assign mem_rdata_en = m_rdata_en;
  assign mem_busy2    = (m_busy2_cnt != 0);

  // Bus activity log, sampled on the falling edge.
  int          cyc = 0, wr_cnt = 0, rd_cnt = 0, consec_viol = 0, ib_viol = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;
  logic [21:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  int          rd_cyc [0:15];
  logic [22:0] ev2 [$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    if ((mem_wr && prev_wr) || (mem_rd && prev_rd)) consec_viol++;
    if ((mem_wr || mem_rd) && mem_initial_busy) ib_viol++;
    if (mem_wr) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = mem_address;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
    if (mem_rd) begin
      rd_cyc[mem_address[3:0]] = cyc;
      rd_cnt++;
    end
    prev_wr = mem_wr;
    prev_rd = mem_rd;
    if (mem_wr2 || mem_rd2) ev2.push_back({mem_rd2, mem_address2});
  endtask

  task automatic clear_log();
    wr_cnt = 0; rd_cnt = 0; consec_viol = 0; ib_viol = 0;
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    pattern_sel = sel;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%0b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h, required 0", outs); end
    checks++;
    if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addr_pattern();
    clear_log();
    pulse_start(2'd0);
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL t1_running: got %0b, required 1", running); end
    wait_done("t1");
    checks++;
    if ({pass, error_count, running} !== {1'b1, 16'd0, 1'b0}) begin
      failures++; $display("FAIL t1_status: pass=%0b errs=%0d running=%0b, required 1/0/0", pass, error_count, running);
    end
    checks++;
    if (wr_cnt !== 16 || rd_cnt !== 16) begin failures++; $display("FAIL t1_counts: wr=%0d rd=%0d, required 16/16", wr_cnt, rd_cnt); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wr_addr[i] !== 22'(i) || wr_data[i] !== 8'(i)) begin
        failures++; $display("FAIL t1_wr%0d: addr=%h data=%h, required %h/%h", i, wr_addr[i], wr_data[i], i, i);
      end
    end
  endtask

  task automatic test_lfsr_mismatch();
    logic [7:0] lfsr_tab [0:5] = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27};
    clear_log();
    flip_en = 1'b1;
    pulse_start(2'd1);
    wait_done("t2");
    flip_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wr_data[i] !== lfsr_tab[i]) begin failures++; $display("FAIL t2_lfsr%0d: got %h, required %h", i, wr_data[i], lfsr_tab[i]); end
    end
    checks++;
    if (error_count !== 16'd1 || pass !== 1'b0 || timeout_seen !== 1'b0) begin
      failures++; $display("FAIL t2_status: errs=%0d pass=%0b tmo=%0b, required 1/0/0", error_count, pass, timeout_seen);
    end
    checks++;
    if ({first_err_addr, first_err_exp, first_err_act} !== {22'd5, 8'h27, 8'h26}) begin
      failures++; $display("FAIL t2_first_err: addr=%h exp=%h act=%h, required 5/27/26", first_err_addr, first_err_exp, first_err_act);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    drop_en = 1'b1;
    pulse_start(2'd2);
    wait_done("t3");
    drop_en = 1'b0;
    checks++;
    if (rd_cyc[3] - rd_cyc[2] !== 7) begin failures++; $display("FAIL t3_normal_gap: got %0d, required 7", rd_cyc[3] - rd_cyc[2]); end
    // One issue cycle plus 255 waiting cycles.
    checks++;
    if (rd_cyc[4] - rd_cyc[3] !== 256) begin failures++; $display("FAIL t3_timeout_gap: got %0d, required 256", rd_cyc[4] - rd_cyc[3]); end
    checks++;
    if (timeout_seen !== 1'b1 || error_count !== 16'd1 || pass !== 1'b0) begin
      failures++; $display("FAIL t3_status: tmo=%0b errs=%0d pass=%0b, required 1/1/0", timeout_seen, error_count, pass);
    end
    checks++;
    if ({first_err_addr, first_err_exp, first_err_act} !== {22'd3, 8'hAA, 8'h00}) begin
      failures++; $display("FAIL t3_first_err: addr=%h exp=%h act=%h, required 3/AA/00", first_err_addr, first_err_exp, first_err_act);
    end
  endtask

  task automatic test_init_busy();
    clear_log();
    mem_initial_busy = 1'b1;
    pulse_start(2'd3);
    repeat (100) tick();
    checks++;
    if (wr_cnt !== 0 || rd_cnt !== 0 || running !== 1'b1) begin
      failures++; $display("FAIL t4_held: wr=%0d rd=%0d running=%0b, required 0/0/1", wr_cnt, rd_cnt, running);
    end
    mem_initial_busy = 1'b0;
    wait_done("t4");
    checks++;
    if (consec_viol !== 0 || ib_viol !== 0) begin
      failures++; $display("FAIL t4_protocol: consecutive=%0d during_init=%0d, required 0/0", consec_viol, ib_viol);
    end
    checks++;
    if (pass !== 1'b1 || wr_data[0] !== 8'h00 || wr_data[1] !== 8'hFF) begin
      failures++; $display("FAIL t4_result: pass=%0b d0=%h d1=%h, required 1/00/FF", pass, wr_data[0], wr_data[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    clear_log();
    pulse_start(2'd0);
    while (rd_cnt < 8 && n < 1000) begin tick(); n++; end
    checks++;
    if (rd_cnt < 8) begin failures++; $display("FAIL t5_reach: rd=%0d, required 8", rd_cnt); end
    tick();
    checks++;
    if (dut.state_q !== S_RD_WAIT) begin failures++; $display("FAIL t5_in_rd_wait: state=%0d, required RD_WAIT", dut.state_q); end
    reset = 1'b1;
    tick();
    checks++;
    if (outs !== '0 || dut.state_q !== S_IDLE) begin
      failures++; $display("FAIL t5_reset: outs=%h state=%0d, required 0/IDLE", outs, dut.state_q);
    end
    reset = 1'b0;
    clear_log();
    pulse_start(2'd0);
    wait_done("t5");
    checks++;
    if (wr_addr[0] !== 22'd0 || wr_cnt !== 16 || pass !== 1'b1) begin
      failures++; $display("FAIL t5_rerun: a0=%h wr=%0d pass=%0b, required 0/16/1", wr_addr[0], wr_cnt, pass);
    end
  endtask

  task automatic test_end_boundary();
    int n = 0;
    reset2 = 1'b0;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    while (!mem_wr2 && n < 50) begin tick(); n++; end
    checks++;
    if (mem_wr2 !== 1'b1) begin failures++; $display("FAIL t6_first_wr: got %0b, required 1", mem_wr2); end
    tick();
    force dut2.addr_q = 22'h3FFFFE;
    tick();
    release dut2.addr_q;
    ev2.delete();
    n = 0;
    while (ev2.size() < 2 && n < 200) begin tick(); n++; end
    checks++;
    if (ev2.size() < 2) begin
      failures++; $display("FAIL t6_events: got %0d bus events, required 2", ev2.size());
    end else begin
      checks++;
      if (ev2[0] !== {1'b0, 22'h3FFFFF}) begin failures++; $display("FAIL t6_last_wr: got %h, required wr@3FFFFF", ev2[0]); end
      checks++;
      if (ev2[1] !== {1'b1, 22'h000000}) begin failures++; $display("FAIL t6_first_rd: got %h, required rd@000000", ev2[1]); end
    end
    reset2 = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addr_pattern();
    test_lfsr_mismatch();
    test_timeout();
    test_init_busy();
    test_reset_mid_read();
    test_end_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
